// File: rtl/clk_rst_pkg.sv
// Shared types and defaults for the clock-wizard reset sequencer.
// Optional status counter in clk_rst_seq is enabled by CLK_RST_SEQ_STATUS_EN.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;

  localparam int unsigned DEF_RST_CYCLES    = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 1024;
  localparam int unsigned DEF_STABLE_CYCLES = 16;
  localparam int unsigned DEF_MAX_RETRIES   = 3;
  localparam int unsigned LOSS_CNT_W        = 8;

  // Registered sequencer outputs, decoded from the state being entered
  typedef struct packed {
    logic pll_reset;
    logic sys_reset_n;
    logic fault;
  } seq_out_t;

  localparam seq_out_t OUT_RESET = '{pll_reset: 1'b1, sys_reset_n: 1'b0, fault: 1'b0};

  // Width of a counter that must hold 0..max_val; never narrower than 1 bit
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? int'($clog2(max_val + 1)) : 1;
  endfunction

  // Output levels associated with each state
  function automatic seq_out_t decode_outputs(input seq_state_t s);
    seq_out_t o;
    o.pll_reset   = (s == RESET_PLL);
    o.sys_reset_n = (s == RUN);
    o.fault       = (s == FAULT);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the raw input through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer for the clock wizard: pulses the wizard reset, waits
// for a stable lock, then releases the system reset. Lock loss re-runs the
// sequence; exhausted retries park in a sticky fault until restart/reset_n.
// Define CLK_RST_SEQ_STATUS_EN to add the lock_loss_cnt status output.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  localparam int unsigned RETRY_W      = cnt_width(MAX_RETRIES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               locked,
  input  logic               restart,
  output logic               pll_reset,
  output logic               sys_reset_n,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef CLK_RST_SEQ_STATUS_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

  localparam int unsigned RST_W = cnt_width(RST_CYCLES);
  localparam int unsigned TO_W  = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned STB_W = cnt_width(STABLE_CYCLES);

  seq_state_t         state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  seq_out_t           out_q, out_d;
  logic               lock_s;

  // Bring the wizard lock into the clk domain
  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (locked),
    .q     (lock_s)
  );

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_PLL;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      stb_cnt_q <= '0;
      retry_q   <= '0;
      out_q     <= OUT_RESET;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stb_cnt_q <= stb_cnt_d;
      retry_q   <= retry_d;
      out_q     <= out_d;
    end
  end

  // Next state and counter updates; restart wins over lock loss over timers.
  // The lock_s=1 cycle that moves WAIT_LOCK to STABLE is the first stable
  // cycle, so STABLE finishes when the cleared counter plus that cycle plus
  // the current one reaches STABLE_CYCLES.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    stb_cnt_d = stb_cnt_q;
    retry_d   = retry_q;

    if (restart) begin
      state_d   = RESET_PLL;
      rst_cnt_d = '0;
      retry_d   = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (rst_cnt_q >= RST_W'(RST_CYCLES - 1)) begin
            state_d  = WAIT_LOCK;
            to_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_s) begin
            if (STABLE_CYCLES <= 1) begin
              state_d = RUN;
              retry_d = '0;
            end else begin
              state_d   = STABLE;
              stb_cnt_d = '0;
            end
          end else if (to_cnt_q >= TO_W'(LOCK_TIMEOUT - 1)) begin
            if (retry_q < RETRY_W'(MAX_RETRIES)) begin
              state_d   = RESET_PLL;
              rst_cnt_d = '0;
              retry_d   = retry_q + RETRY_W'(1);
            end else begin
              state_d = FAULT;
            end
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end

        STABLE: begin
          if (!lock_s) begin
            state_d  = WAIT_LOCK;
            to_cnt_d = '0;
          end else if ((32'(stb_cnt_q) + 32'd2) >= STABLE_CYCLES) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            stb_cnt_d = stb_cnt_q + STB_W'(1);
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_d   = RESET_PLL;
            rst_cnt_d = '0;
          end
        end

        FAULT: begin
          state_d = FAULT;
        end

        default: begin
          state_d   = RESET_PLL;
          rst_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the state being entered so they change on
  // the same edge as the transition
  always_comb begin
    out_d = decode_outputs(state_d);
  end

  assign pll_reset   = out_q.pll_reset;
  assign sys_reset_n = out_q.sys_reset_n;
  assign fault       = out_q.fault;
  assign retry_cnt   = retry_q;

`ifdef CLK_RST_SEQ_STATUS_EN
  logic                  lock_loss_c;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  assign lock_loss_c = (state_q == RUN) && !lock_s && !restart;

  // Saturating count of lock losses while running; survives restart
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_loss_c && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
      loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  // Lock-loss counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: randomized lock timing, glitches, timeouts, restart
// and async reset, checked against edge-count predictions from the timing rules.
module tb_clk_rst_seq;
  import clk_rst_pkg::*;

  localparam int unsigned R  = DEF_RST_CYCLES;
  localparam int unsigned T  = DEF_LOCK_TIMEOUT;
  localparam int unsigned S  = DEF_STABLE_CYCLES;
  localparam int unsigned M  = DEF_MAX_RETRIES;
  localparam int unsigned RW = cnt_width(M);

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic          locked  = 1'b0;
  logic          restart = 1'b0;
  logic          pll_reset;
  logic          sys_reset_n;
  logic          fault;
  logic [RW-1:0] retry_cnt;
`ifdef CLK_RST_SEQ_STATUS_EN
  logic [7:0]    lock_loss_cnt;
  int            lost = 0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;
  int base        = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  clk_rst_seq #(
    .RST_CYCLES    (R),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (M)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .locked      (locked),
    .restart     (restart),
    .pll_reset   (pll_reset),
    .sys_reset_n (sys_reset_n),
    .fault       (fault),
    .retry_cnt   (retry_cnt)
`ifdef CLK_RST_SEQ_STATUS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  // Edges since the last reset release
  function automatic int rel();
    return edge_n - base;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return pll_reset;
      1:       return sys_reset_n;
      default: return fault;
    endcase
  endfunction

  // Edge number at which the selected output first shows val; -1 on timeout
  task automatic wait_val(input int sel, input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pick(sel) === val) begin
        at = rel();
        break;
      end
    end
  endtask

  task automatic goto(input int k);
    while (rel() < k) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pll_reset"},   int'(pll_reset),   1);
    chk({tag, "_sys_reset_n"}, int'(sys_reset_n), 0);
    chk({tag, "_fault"},       int'(fault),       0);
    chk({tag, "_retry_cnt"},   int'(retry_cnt),   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;
`ifdef CLK_RST_SEQ_STATUS_EN
    lost = 0;
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    base    = edge_n;
  endtask

  // From reset release: pll pulse of R, then lock d edges later
  task automatic seq_to_run(input int d);
    int at, e;
    wait_val(0, 1'b0, R + 4, at);
    chk("pll_fall", at, R);
    goto(rel() + d);
    e = rel();
    locked = 1'b1;
    wait_val(1, 1'b1, S + 40, at);
    chk("release", at, e + 2 + S);
    chk("retry_in_run", int'(retry_cnt), 0);
  endtask

  // In RUN: drop lock after k edges, then relock g_off edges after the re-pulse
  task automatic lose_and_relock(input int k, input int g_off);
    int at, f, g;
    goto(rel() + k);
    f = rel();
    locked = 1'b0;
`ifdef CLK_RST_SEQ_STATUS_EN
    lost++;
`endif
    wait_val(1, 1'b0, 10, at);
    chk("sys_fall", at, f + 3);
    chk("pll_rise_on_loss", int'(pll_reset), 1);
    wait_val(0, 1'b0, R + 4, at);
    chk("pll_refall", at, f + 3 + R);
    goto(rel() + g_off);
    g = rel();
    locked = 1'b1;
    wait_val(1, 1'b1, S + 40, at);
    chk("re_release", at, g + 2 + S);
`ifdef CLK_RST_SEQ_STATUS_EN
    chk("lock_loss_cnt", int'(lock_loss_cnt), lost);
`endif
  endtask

  // Lock pulse of h edges (too short to release), gap of l, then steady lock
  task automatic glitch_then_lock(input int a_off, input int h, input int l);
    int at, e;
    wait_val(0, 1'b0, R + 4, at);
    chk("pll_fall_glitch", at, R);
    goto(rel() + a_off);
    locked = 1'b1;
    goto(rel() + h);
    locked = 1'b0;
    goto(rel() + l);
    e = rel();
    chk("no_early_release", int'(sys_reset_n), 0);
    locked = 1'b1;
    wait_val(1, 1'b1, S + 40, at);
    chk("glitch_release", at, e + 2 + S);
  endtask

  // Restart while running; lock is already steady when the wizard reset ends
  task automatic restart_in_run();
    int at, y;
    y = rel();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rr_sys_low",  int'(sys_reset_n), 0);
    chk("rr_pll_high", int'(pll_reset),   1);
    wait_val(0, 1'b0, R + 4, at);
    chk("rr_pll_fall", at, y + 1 + R);
    wait_val(1, 1'b1, S + 40, at);
    chk("rr_release", at, y + 1 + R + S);
`ifdef CLK_RST_SEQ_STATUS_EN
    chk("rr_lock_loss_cnt", int'(lock_loss_cnt), lost);
`endif
  endtask

  // Lock never arrives: M retries, then FAULT; restart recovers
  task automatic never_lock();
    int at, x, e;
    wait_val(0, 1'b0, R + 4, at);
    chk("nl_pll_fall0", at, R);
    for (int i = 1; i <= int'(M); i++) begin
      wait_val(0, 1'b1, T + 20, at);
      chk("nl_pll_rise", at, i * int'(R + T));
      chk("nl_retry_cnt", int'(retry_cnt), i);
      wait_val(0, 1'b0, R + 4, at);
      chk("nl_pll_fall", at, i * int'(R + T) + int'(R));
    end
    wait_val(2, 1'b1, T + 20, at);
    chk("nl_fault_at", at, int'(M + 1) * int'(R + T));
    chk("nl_fault_retry", int'(retry_cnt), int'(M));
    chk("nl_fault_pll", int'(pll_reset), 0);
    chk("nl_fault_sys", int'(sys_reset_n), 0);
    repeat (20) @(negedge clk);
    chk("nl_fault_sticky", int'(fault), 1);
    x = rel();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("nl_restart_fault", int'(fault), 0);
    chk("nl_restart_retry", int'(retry_cnt), 0);
    chk("nl_restart_pll", int'(pll_reset), 1);
    wait_val(0, 1'b0, R + 4, at);
    chk("nl_restart_pll_fall", at, x + 1 + R);
    e = rel();
    locked = 1'b1;
    wait_val(1, 1'b1, S + 40, at);
    chk("nl_restart_release", at, e + 2 + S);
  endtask

  initial begin
    int at;
    #1 reset_n = 1'b0;
    #1 chk_reset("por");

    do_reset();
    seq_to_run(20);
    lose_and_relock(int'($urandom_range(1, 30)), int'($urandom_range(0, 40)));

    for (int it = 0; it < 4; it++) begin
      do_reset();
      seq_to_run(int'($urandom_range(1, 80)));
      lose_and_relock(int'($urandom_range(1, 30)), int'($urandom_range(0, 40)));
      do_reset();
      glitch_then_lock(int'($urandom_range(1, 40)), int'($urandom_range(1, 15)),
                       int'($urandom_range(1, 8)));
    end

    restart_in_run();

    do_reset();
    never_lock();

    // Async reset in the middle of STABLE
    do_reset();
    wait_val(0, 1'b0, R + 4, at);
    goto(rel() + 5);
    locked = 1'b1;
    goto(rel() + 8);
    chk("ms_still_stable", int'(sys_reset_n), 0);
    #2 reset_n = 1'b0;
    #1 chk_reset("mid_stable");
    do_reset();
    wait_val(0, 1'b0, R + 4, at);
    chk("ms_pll_fall", at, R);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
